// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed seven-segment scanner with blanking, brightness and frame snapshot
//
// Purpose:
//   Scans DIGITS segment patterns onto one segment bus with one-cold active-low
//   digit enables. Each slot lasts PRESCALE cycles. The first BLANK cycles of a
//   slot are dark to suppress ghosting. The remaining on-time is scaled by
//   `bright` in STEP-cycle increments. Patterns are sampled once per frame
//   into frame_buf, so upstream updates never tear a displayed frame.
//
// Ports:
//   clk        - system clock, rising edge
//   nrst       - asynchronous active-low reset
//   en         - scan enable
//   bright     - brightness, 0 = off, 15 = full on-time
//   seg_bus    - packed patterns, digit i = seg_bus[8*i +: 8]
//   seg_out    - registered segment bus (a..g,dp), active-high
//   an_out     - registered digit enables, active-low one-cold
//   digit_idx  - slot currently being scanned
//   frame_tick - one-cycle pulse as the scan wraps to digit 0

module seg_scan_mux #(
  parameter  int DIGITS   = 8,
  parameter  int PRESCALE = 50000,
  parameter  int BLANK    = 64,
  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [3:0]            bright,
  input  logic [8*DIGITS-1:0]   seg_bus,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_tick
);

  localparam int CW   = $clog2(PRESCALE);
  localparam int STEP = (PRESCALE - BLANK) / 16;
  // BLANK + 15*STEP is always below PRESCALE; one spare bit keeps the
  // threshold arithmetic clear of overflow.
  localparam int TW   = $clog2(PRESCALE + 1) + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [TW-1:0] BLANK_W   = TW'(BLANK);
  localparam logic [TW-1:0] STEP_W    = TW'(STEP);

  logic [CW-1:0]         cnt;
  logic [8*DIGITS-1:0]   frame_buf;
  logic                  en_d;

  logic                  slot_end;
  logic                  last_digit;
  logic                  frame_end;
  logic                  en_rise;
  logic                  on;
  logic [TW-1:0]         cnt_ext;
  logic [TW-1:0]         thresh;
  logic [7:0]            cur_pat;
  logic [DIGITS-1:0]     cur_an;

  // slot_end is gated by en so the cycle in which en falls cannot advance the scan.
  assign slot_end   = en && (cnt == CNT_LAST);
  assign last_digit = (digit_idx == IDX_LAST);
  assign frame_end  = slot_end && last_digit;
  assign en_rise    = en && !en_d;

  assign cnt_ext = TW'(cnt);
  assign thresh  = BLANK_W + TW'(bright) * STEP_W;

  // Full brightness ignores the threshold so the slot stays lit to its last cycle.
  assign on = en && (cnt_ext >= BLANK_W) && ((bright == 4'hF) || (cnt_ext < thresh));

  assign cur_pat = frame_buf[{digit_idx, 3'b000} +: 8];
  assign cur_an  = ~(DIGITS'(1) << digit_idx);

  // Prescaler and slot index
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (!en) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      cnt       <= '0;
      digit_idx <= last_digit ? '0 : digit_idx + 1'b1;
    end else begin
      cnt       <= cnt + 1'b1;
    end
  end

  // Frame snapshot: loads when scanning starts and at each frame boundary only.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_buf <= '0;
    end else if (en_rise || frame_end) begin
      frame_buf <= seg_bus;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_d <= 1'b0;
    end else begin
      en_d <= en;
    end
  end

  // Output register: one cycle behind (cnt, digit_idx). Segments are forced
  // to zero whenever every digit is off.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg_out    <= 8'h00;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (on) begin
        seg_out <= cur_pat;
        an_out  <= cur_an;
      end else begin
        seg_out <= 8'h00;
        an_out  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed table-driven bench for seg_scan_mux

module tb_seg_scan_mux;

  logic        clk;
  logic        nrst;
  logic        en;
  logic [3:0]  bright;
  logic [63:0] seg_bus;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int checks;
  int errors;
  int n;

  seg_scan_mux #(
    .DIGITS   (8),
    .PRESCALE (20),
    .BLANK    (2)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .bright     (bright),
    .seg_bus    (seg_bus),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] seg;
    logic [2:0] idx;
    logic       tick;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int c);
    while (n < c) step();
  endtask

  function automatic logic [63:0] pat(input logic [7:0] base);
    logic [63:0] b;
    for (int i = 0; i < 8; i++) b[8*i +: 8] = base + 8'(i);
    return b;
  endfunction

  // en low for two edges, then raised; the next edge is the en-rise cycle 0.
  task automatic start_scan();
    en = 1'b0;
    step();
    step();
    en = 1'b1;
    n = 0;
  endtask

  task automatic count_on(input logic [3:0] b, input int exp_on);
    int on_cnt;
    int bad;
    bright = b;
    start_scan();
    on_cnt = 0;
    bad = 0;
    for (int k = 1; k <= 160; k++) begin
      step();
      if (an_out != 8'hFF) on_cnt++;
      if (an_out == 8'hFF && seg_out != 8'h00) bad++;
      if (b == 4'd4 && k == 2) chk("b4_cyc2_off", an_out, 8'hFF);
      if (b == 4'd4 && k == 3) chk("b4_cyc3_on", an_out, 8'hFE);
      if (b == 4'd4 && k == 6) chk("b4_cyc6_on", an_out, 8'hFE);
      if (b == 4'd4 && k == 7) chk("b4_cyc7_off", an_out, 8'hFF);
    end
    chk($sformatf("on_cycles_b%0d", b), on_cnt, exp_on);
    chk($sformatf("seg_dark_b%0d", b), bad, 0);
  endtask

  initial begin
    int ticks[$];
    int idx_bad;
    int tick_seen;

    checks = 0;
    errors = 0;
    n = 0;

    tbl[0]  = '{1,   8'hFF, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{2,   8'hFF, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{3,   8'hFE, 8'h10, 3'd0, 1'b0};
    tbl[3]  = '{20,  8'hFE, 8'h10, 3'd1, 1'b0};
    tbl[4]  = '{21,  8'hFF, 8'h00, 3'd1, 1'b0};
    tbl[5]  = '{22,  8'hFF, 8'h00, 3'd1, 1'b0};
    tbl[6]  = '{23,  8'hFD, 8'h11, 3'd1, 1'b0};
    tbl[7]  = '{40,  8'hFD, 8'h11, 3'd2, 1'b0};
    tbl[8]  = '{43,  8'hFB, 8'h12, 3'd2, 1'b0};
    tbl[9]  = '{159, 8'h7F, 8'h17, 3'd7, 1'b0};
    tbl[10] = '{160, 8'h7F, 8'h17, 3'd0, 1'b1};
    tbl[11] = '{161, 8'hFF, 8'h00, 3'd0, 1'b0};
    tbl[12] = '{163, 8'hFE, 8'h10, 3'd0, 1'b0};

    nrst    = 1'b0;
    en      = 1'b0;
    bright  = 4'hF;
    seg_bus = pat(8'h10);
    step();
    step();
    chk("rst_seg", seg_out, 8'h00);
    chk("rst_an", an_out, 8'hFF);
    chk("rst_idx", digit_idx, 3'd0);
    chk("rst_tick", frame_tick, 1'b0);

    // Reset asserted mid-scan between clock edges
    nrst = 1'b1;
    start_scan();
    run_to(65);
    chk("pre_rst_an", an_out, 8'hF7);
    seg_bus = '1;
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_seg", seg_out, 8'h00);
    chk("async_rst_an", an_out, 8'hFF);
    chk("async_rst_idx", digit_idx, 3'd0);
    chk("async_rst_tick", frame_tick, 1'b0);
    step();
    nrst = 1'b1;

    // Scan order table
    seg_bus = pat(8'h10);
    bright  = 4'hF;
    start_scan();
    for (int i = 0; i < 13; i++) begin
      run_to(tbl[i].cyc);
      chk($sformatf("tbl%0d_an", i), an_out, tbl[i].an);
      chk($sformatf("tbl%0d_seg", i), seg_out, tbl[i].seg);
      chk($sformatf("tbl%0d_idx", i), digit_idx, tbl[i].idx);
      chk($sformatf("tbl%0d_tick", i), frame_tick, tbl[i].tick);
    end

    // Tearing: digit 5 changes during slot 2
    seg_bus = pat(8'h10);
    start_scan();
    run_to(45);
    seg_bus[47:40] = 8'hAA;
    run_to(110);
    chk("tear_cur_an", an_out, 8'hDF);
    chk("tear_cur_seg", seg_out, 8'h15);
    run_to(270);
    chk("tear_next_an", an_out, 8'hDF);
    chk("tear_next_seg", seg_out, 8'hAA);

    // Brightness: on-cycles per 8-slot frame
    seg_bus = pat(8'h10);
    count_on(4'd4, 32);
    count_on(4'd0, 0);
    count_on(4'd15, 144);
    bright = 4'hF;

    // Enable drop during digit 3 and restart with a fresh snapshot
    start_scan();
    run_to(70);
    chk("drop_pre_an", an_out, 8'hF7);
    chk("drop_pre_seg", seg_out, 8'h13);
    en = 1'b0;
    step();
    chk("drop_an", an_out, 8'hFF);
    chk("drop_seg", seg_out, 8'h00);
    chk("drop_idx", digit_idx, 3'd0);
    seg_bus = pat(8'h20);
    tick_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (frame_tick) tick_seen++;
    end
    chk("drop_no_tick", tick_seen, 0);
    chk("drop_idle_an", an_out, 8'hFF);
    en = 1'b1;
    n = 0;
    run_to(3);
    chk("resume_an", an_out, 8'hFE);
    chk("resume_seg", seg_out, 8'h20);
    run_to(23);
    chk("resume2_an", an_out, 8'hFD);
    chk("resume2_seg", seg_out, 8'h21);

    // Wrap: three frames
    start_scan();
    idx_bad = 0;
    for (int k = 1; k <= 485; k++) begin
      step();
      if (frame_tick) ticks.push_back(n);
      if (int'(digit_idx) != (n / 20) % 8) idx_bad++;
    end
    chk("wrap_idx_track", idx_bad, 0);
    chk("wrap_tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      chk("wrap_first_tick", ticks[0], 160);
      chk("wrap_period1", ticks[1] - ticks[0], 160);
      chk("wrap_period2", ticks[2] - ticks[1], 160);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
